// File: rtl/rgb_hsv_pkg.sv
// Shared constants and types for the RGB/HSV conversion pair.
// The HSV-to-RGB stage imports the same hue and saturation constants.
package rgb_hsv_pkg;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_t;

  localparam logic [8:0] HUE_SECTOR = 9'd60;
  localparam logic [8:0] HUE_G      = 9'd120;
  localparam logic [8:0] HUE_B      = 9'd240;
  localparam logic [8:0] HUE_WRAP   = 9'd360;
  localparam logic [8:0] SAT_FULL   = 9'd256;

  // magnitude of a signed channel difference (always fits 8 bits)
  function automatic logic [7:0] abs9(input logic signed [8:0] x);
    return 8'(x[8] ? -x : x);
  endfunction

endpackage

// File: rtl/rgb_maxmin.sv
// Combinational max/min, dominant channel select and signed hue numerator.
// Ties resolve R over G over B.
module rgb_maxmin
  import rgb_hsv_pkg::*;
(
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic [7:0]        max,
  output logic [7:0]        min,
  output sel_t              sel,
  output logic signed [8:0] num
);

  always_comb begin
    max = r;
    min = r;
    sel = SEL_R;
    num = 9'sd0;
    if (r >= g && r >= b) begin
      max = r;
      sel = SEL_R;
      num = $signed({1'b0, g}) - $signed({1'b0, b});
    end else if (g >= b) begin
      max = g;
      sel = SEL_G;
      num = $signed({1'b0, b}) - $signed({1'b0, r});
    end else begin
      max = b;
      sel = SEL_B;
      num = $signed({1'b0, r}) - $signed({1'b0, g});
    end
    if (g < min) min = g;
    if (b < min) min = b;
  end

endmodule

// File: rtl/rgb_hsv.sv
// Four-stage pipelined RGB888 to HSV converter with aligned vs/hs/de.
// Define RGB_HSV_DE_GATE_EN to zero h/s/v whenever the delayed de is low.
module rgb_hsv
  import rgb_hsv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_rgb_r,
  input  logic [7:0] i_rgb_g,
  input  logic [7:0] i_rgb_b,
  input  logic       vs,
  input  logic       hs,
  input  logic       de,
  output logic [8:0] hsv_h,
  output logic [8:0] hsv_s,
  output logic [7:0] hsv_v,
  output logic       hsv_vs,
  output logic       hsv_hs,
  output logic       hsv_de
);

  logic [7:0]        mm_max, mm_min;
  sel_t              mm_sel;
  logic signed [8:0] mm_num;

  logic [7:0]        s1_max, s1_min;
  sel_t              s1_sel;
  logic signed [8:0] s1_num;

  logic [7:0]        s2_max, s2_delta;
  sel_t              s2_sel;
  logic signed [8:0] s2_num;

  logic [5:0]        s3_frac;
  logic [8:0]        s3_sat;
  logic [7:0]        s3_max;
  sel_t              s3_sel;
  logic              s3_neg, s3_dz;

  logic [3:0]        vs_sr, hs_sr, de_sr;

  logic [13:0]       hue_prod;
  logic [15:0]       sat_prod;
  logic [7:0]        hue_div, sat_div;
  logic [5:0]        frac_c;
  logic [8:0]        sat_c;
  logic [8:0]        hue_c;
  logic [8:0]        frac9;

  rgb_maxmin u_maxmin (
    .r   (i_rgb_r),
    .g   (i_rgb_g),
    .b   (i_rgb_b),
    .max (mm_max),
    .min (mm_min),
    .sel (mm_sel),
    .num (mm_num)
  );

  // Dividers never see zero: the zero-delta / zero-max cases are forced instead.
  always_comb begin
    hue_prod = {6'b0, abs9(s2_num)} * {5'b0, HUE_SECTOR};
    sat_prod = {8'b0, s2_delta} * {7'b0, SAT_FULL};
    hue_div  = (s2_delta == 8'd0) ? 8'd1 : s2_delta;
    sat_div  = (s2_max == 8'd0) ? 8'd1 : s2_max;
    frac_c   = (s2_delta == 8'd0) ? 6'd0 : 6'(hue_prod / {6'b0, hue_div});
    sat_c    = (s2_max == 8'd0) ? 9'd0 : 9'(sat_prod / {8'b0, sat_div});
  end

  always_comb begin
    frac9 = {3'b0, s3_frac};
    hue_c = 9'd0;
    case (s3_sel)
      SEL_R:   hue_c = s3_neg ? (HUE_WRAP - frac9) : frac9;
      SEL_G:   hue_c = s3_neg ? (HUE_G - frac9) : (HUE_G + frac9);
      SEL_B:   hue_c = s3_neg ? (HUE_B - frac9) : (HUE_B + frac9);
      default: hue_c = 9'd0;
    endcase
    if (hue_c == HUE_WRAP || s3_dz) hue_c = 9'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_max   <= 8'd0;
      s1_min   <= 8'd0;
      s1_sel   <= SEL_R;
      s1_num   <= 9'sd0;
      s2_max   <= 8'd0;
      s2_delta <= 8'd0;
      s2_sel   <= SEL_R;
      s2_num   <= 9'sd0;
      s3_frac  <= 6'd0;
      s3_sat   <= 9'd0;
      s3_max   <= 8'd0;
      s3_sel   <= SEL_R;
      s3_neg   <= 1'b0;
      s3_dz    <= 1'b0;
      hsv_h    <= 9'd0;
      hsv_s    <= 9'd0;
      hsv_v    <= 8'd0;
      vs_sr    <= 4'd0;
      hs_sr    <= 4'd0;
      de_sr    <= 4'd0;
    end else begin
      s1_max   <= mm_max;
      s1_min   <= mm_min;
      s1_sel   <= mm_sel;
      s1_num   <= mm_num;

      s2_max   <= s1_max;
      s2_delta <= s1_max - s1_min;
      s2_sel   <= s1_sel;
      s2_num   <= s1_num;

      s3_frac  <= frac_c;
      s3_sat   <= sat_c;
      s3_max   <= s2_max;
      s3_sel   <= s2_sel;
      s3_neg   <= s2_num[8];
      s3_dz    <= (s2_delta == 8'd0);

`ifdef RGB_HSV_DE_GATE_EN
      // de_sr[2] is the de that lands on hsv_de together with this result
      if (de_sr[2]) begin
        hsv_h <= hue_c;
        hsv_s <= s3_sat;
        hsv_v <= s3_max;
      end else begin
        hsv_h <= 9'd0;
        hsv_s <= 9'd0;
        hsv_v <= 8'd0;
      end
`else
      hsv_h <= hue_c;
      hsv_s <= s3_sat;
      hsv_v <= s3_max;
`endif

      vs_sr <= {vs_sr[2:0], vs};
      hs_sr <= {hs_sr[2:0], hs};
      de_sr <= {de_sr[2:0], de};
    end
  end

  assign hsv_vs = vs_sr[3];
  assign hsv_hs = hs_sr[3];
  assign hsv_de = de_sr[3];

endmodule

// File: tb/tb_rgb_hsv.sv
// Self-checking bench for rgb_hsv: arithmetic reference model plus literal vectors.
// Honours RGB_HSV_DE_GATE_EN the same way the design does.
module tb_rgb_hsv;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] s;
    logic [7:0] v;
    logic       vs;
    logic       hs;
    logic       de;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [8:0] hsv_h, hsv_s;
  logic [7:0] hsv_v;
  logic       hsv_vs, hsv_hs, hsv_de;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;
  exp_t expq [4];

  always #5 clk = ~clk;

  rgb_hsv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rgb_r (r),
    .i_rgb_g (g),
    .i_rgb_b (b),
    .vs      (vs),
    .hs      (hs),
    .de      (de),
    .hsv_h   (hsv_h),
    .hsv_s   (hsv_s),
    .hsv_v   (hsv_v),
    .hsv_vs  (hsv_vs),
    .hsv_hs  (hsv_hs),
    .hsv_de  (hsv_de)
  );

  // Reference: hue from the dominant channel, 60 degrees per sector.
  function automatic exp_t model(input int ri, input int gi, input int bi,
                                 input logic v_s, input logic h_s, input logic d_e);
    int mx, mn, d, num, base, frac, h, s;
    exp_t e;
    mx = ri; if (gi > mx) mx = gi; if (bi > mx) mx = bi;
    mn = ri; if (gi < mn) mn = gi; if (bi < mn) mn = bi;
    d = mx - mn;
    if (ri >= gi && ri >= bi) begin num = gi - bi; base = 0; end
    else if (gi >= bi)        begin num = bi - ri; base = 120; end
    else                      begin num = ri - gi; base = 240; end
    if (d == 0) h = 0;
    else begin
      frac = ((num < 0) ? -num : num) * 60 / d;
      h = (num >= 0) ? base + frac : base - frac;
      if (h < 0) h = h + 360;
      if (h >= 360) h = h - 360;
    end
    s = (mx == 0) ? 0 : d * 256 / mx;
`ifdef RGB_HSV_DE_GATE_EN
    if (!d_e) begin h = 0; s = 0; mx = 0; end
`endif
    e.h = 9'(h); e.s = 9'(s); e.v = 8'(mx);
    e.vs = v_s; e.hs = h_s; e.de = d_e;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) expq[i] <= '0;
    end else begin
      expq[0] <= model(int'(r), int'(g), int'(b), vs, hs, de);
      for (int i = 1; i < 4; i++) expq[i] <= expq[i-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_h", 32'(hsv_h), 32'(expq[3].h));
      chk("model_s", 32'(hsv_s), 32'(expq[3].s));
      chk("model_v", 32'(hsv_v), 32'(expq[3].v));
      chk("model_vs", 32'(hsv_vs), 32'(expq[3].vs));
      chk("model_hs", 32'(hsv_hs), 32'(expq[3].hs));
      chk("model_de", 32'(hsv_de), 32'(expq[3].de));
    end
  end

  task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                       input logic v_s, input logic h_s, input logic d_e);
    @(posedge clk);
    #1;
    r = rr; g = gg; b = bb; vs = v_s; hs = h_s; de = d_e;
  endtask

  task automatic check_out(input string name, input int h, input int s, input int v, input logic d_e);
    chk({name, "_h"}, 32'(hsv_h), 32'(h));
    chk({name, "_s"}, 32'(hsv_s), 32'(s));
    chk({name, "_v"}, 32'(hsv_v), 32'(v));
    chk({name, "_de"}, 32'(hsv_de), 32'(d_e));
  endtask

  // One pixel, then blanking; result must show after exactly the fourth edge.
  task automatic pin(input string name, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                     input logic d_e, input int h, input int s, input int v);
    drive(rr, gg, bb, 1'b0, 1'b0, d_e);
    for (int i = 0; i < 3; i++) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_out(name, h, s, v, d_e);
  endtask

  initial begin
    exp_t m;
    #2 reset_n = 1'b0;
    #2;
    check_out("reset", 0, 0, 0, 1'b0);
    chk("reset_vs", 32'(hsv_vs), 32'd0);
    chk("reset_hs", 32'(hsv_hs), 32'd0);
    chk_en = 1'b1;
    #18 reset_n = 1'b1;

    m = model(200, 200, 50, 1'b0, 1'b0, 1'b1);
    chk("pin_model_h", 32'(m.h), 32'd60);
    chk("pin_model_s", 32'(m.s), 32'd192);
    m = model(255, 0, 1, 1'b0, 1'b0, 1'b1);
    chk("pin_model_wrap", 32'(m.h), 32'd0);

    pin("red",   8'd255, 8'd0,   8'd0,   1'b1, 0,   256, 255);
    pin("green", 8'd0,   8'd255, 8'd0,   1'b1, 120, 256, 255);
    pin("blue",  8'd0,   8'd0,   8'd255, 1'b1, 240, 256, 255);
    pin("grey",  8'd128, 8'd128, 8'd128, 1'b1, 0,   0,   128);
    pin("black", 8'd0,   8'd0,   8'd0,   1'b1, 0,   0,   0);
    pin("wrap",  8'd255, 8'd0,   8'd1,   1'b1, 0,   256, 255);
    pin("orange",8'd255, 8'd128, 8'd0,   1'b1, 30,  256, 255);
    pin("tie",   8'd200, 8'd200, 8'd50,  1'b1, 60,  192, 200);
`ifdef RGB_HSV_DE_GATE_EN
    pin("degate",8'd255, 8'd128, 8'd0,   1'b0, 0,   0,   0);
`else
    pin("degate",8'd255, 8'd128, 8'd0,   1'b0, 30,  256, 255);
`endif

    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_out("midreset", 0, 0, 0, 1'b0);
        chk("midreset_vs", 32'(hsv_vs), 32'd0);
        chk("midreset_hs", 32'(hsv_hs), 32'd0);
        r = 8'd0; g = 8'd255; b = 8'd0; vs = 1'b0; hs = 1'b0; de = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_out("postreset", 120, 256, 255, 1'b1);
      end
      drive(8'(i * 37), 8'(i * 91 + 13), 8'(255 - i * 23),
            (i < 2), (i % 10 < 3), (i >= 6 && i < 34));
    end
    for (int i = 0; i < 6; i++) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
